// File: rtl/seq_player_pkg.sv
// seq_player_pkg: shared game constants and the playback state encoding.
package seq_player_pkg;

    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [5:0] MAX_LEN = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHOW,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/seq_player.sv
// seq_player: plays a stored digit sequence from RAM to the display,
// one digit per tick with a blank gap between digits.
module seq_player
    import seq_player_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] len,
    input  logic       tick,
    output logic       tick_en,
    output logic [4:0] ram_addr,
    input  logic [3:0] ram_q,
    output logic [3:0] disp_digit,
    output logic       disp_valid,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [4:0] index, index_nx;
    logic [5:0] len_q, len_nx;
    logic [3:0] digit_nx;
    logic       valid_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            len_q      <= '0;
            disp_digit <= BLANK;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            index      <= index_nx;
            len_q      <= len_nx;
            disp_digit <= digit_nx;
            disp_valid <= valid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        index_nx = index;
        len_nx   = len_q;
        digit_nx = disp_digit;
        valid_nx = disp_valid;
        case (state)
            IDLE: if (start) begin
                len_nx   = (len > MAX_LEN) ? MAX_LEN : len;
                index_nx = '0;
                state_nx = (len == 6'd0) ? DONE : FETCH;
            end
            FETCH: state_nx = WAIT;
            WAIT: begin
                digit_nx = ram_q;
                valid_nx = 1'b1;
                state_nx = SHOW;
            end
            SHOW: if (tick) begin
                digit_nx = BLANK;
                valid_nx = 1'b0;
                state_nx = GAP;
            end
            GAP: if (tick) begin
                // len_q is at least 1 here, so len_q-1 never underflows
                if ({1'b0, index} == len_q - 6'd1) state_nx = DONE;
                else begin
                    index_nx = index + 5'd1;
                    state_nx = FETCH;
                end
            end
            DONE: begin
                index_nx = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            index_nx = '0;
            digit_nx = BLANK;
            valid_nx = 1'b0;
        end
    end

    assign ram_addr = index;
    assign tick_en  = (state == SHOW) || (state == GAP);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: plans each run as a timeline of expected outputs per cycle
// (derived from start/tick/abort/reset times) and compares every cycle.
module tb_seq_player;

    localparam int N = 1000;
    localparam int S = 2;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, tick = 1'b0;
    logic [5:0] len = '0;
    logic [3:0] ram_q = '0;
    logic       tick_en, disp_valid, busy, done;
    logic [4:0] ram_addr;
    logic [3:0] disp_digit;

    seq_player dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .tick(tick), .tick_en(tick_en), .ram_addr(ram_addr), .ram_q(ram_q),
        .disp_digit(disp_digit), .disp_valid(disp_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [32];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int vectors = 0, errs = 0, cyc = -1;
    bit tk [N], st [N], ab [N], rs [N];
    logic [3:0] e_digit [N];
    bit e_valid [N], e_done [N], e_busy [N], e_ten [N];
    int e_addr [N];
    int show_at [32], gap_at [32], end_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    // Expected timeline: a digit is visible from 3 cycles after its trigger
    // (start or gap tick) until the first tick seen while it is shown.
    task automatic plan(input int ln, input int period);
        int l, t, c0, g;
        l = (ln > 32) ? 32 : ln;
        len = 6'(ln);
        for (int c = 0; c < N; c++) begin
            tk[c] = (period > 0) ? (c % period == period - 1) : ($urandom_range(0, 3) == 0);
            st[c] = 0; ab[c] = 0; rs[c] = 0;
            e_digit[c] = 4'hF; e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_ten[c] = 0;
            e_addr[c] = -1;
        end
        st[S] = 1;
        t = S;
        for (int k = 0; k < l; k++) begin
            e_addr[t + 1] = k;
            c0 = t + 3;
            while (c0 < N - 8 && !tk[c0]) c0++;
            g = c0 + 1;
            while (g < N - 6 && !tk[g]) g++;
            show_at[k] = t + 3;
            gap_at[k] = c0 + 1;
            for (int c = t + 1; c <= g; c++) e_busy[c] = 1;
            for (int c = t + 3; c <= c0; c++) begin e_digit[c] = mem[k]; e_valid[c] = 1; end
            for (int c = t + 3; c <= g; c++) e_ten[c] = 1;
            t = g;
        end
        e_busy[t + 1] = 1;
        e_done[t + 1] = 1;
        end_cyc = t + 1;
    endtask

    task automatic kill(input int kc, input bit is_rst);
        if (is_rst) rs[kc] = 1; else ab[kc] = 1;
        for (int c = kc + 1; c < N; c++) begin
            e_digit[c] = 4'hF; e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_ten[c] = 0;
            e_addr[c] = (is_rst && c == kc + 1) ? 0 : -1;
        end
        end_cyc = kc;
    endtask

    task automatic add_starts(input int n);
        for (int i = 0; i < n; i++)
            if (end_cyc > S) st[$urandom_range(S + 1, end_cyc)] = 1;
    endtask

    task automatic run();
        for (int c = 0; c < N; c++) begin
            cyc = c;
            start = st[c]; tick = tk[c]; abort = ab[c]; rst = rs[c];
            @(negedge clk);
            check("digit", disp_digit, e_digit[c]);
            check("valid", disp_valid, e_valid[c]);
            check("done", done, e_done[c]);
            check("busy", busy, e_busy[c]);
            check("tick_en", tick_en, e_ten[c]);
            if (e_addr[c] >= 0) check("ram_addr", ram_addr, e_addr[c]);
            @(posedge clk);
            #1;
        end
        start = 0; tick = 0; abort = 0; rst = 0;
    endtask

    initial begin
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit", disp_digit, 4'hF);
        check("rst_valid", disp_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tick_en", tick_en, 1'b0);
        check("rst_addr", ram_addr, 5'd0);
        rst = 0;
        mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd1;
        plan(3, 20);
        add_starts(4);
        run();
        plan(0, 7);
        run();
        fill_mem();
        plan(40, 0);
        add_starts(3);
        run();
        fill_mem();
        plan(5, 0);
        kill(show_at[1], 0);
        run();
        plan(5, 0);
        run();
        fill_mem();
        plan(4, 0);
        kill(gap_at[0], 1);
        run();
        for (int r = 0; r < 10; r++) begin
            fill_mem();
            plan($urandom_range(0, 45), $urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) kill($urandom_range(S, end_cyc), 1'($urandom_range(0, 1)));
            add_starts(3);
            run();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse from game controller; begin playback
abort  in  1  one-cycle pulse; cancel playback (logout/timeout)
len  in  6  number of digits to play, 0..63
tick  in  1  one-cycle pacing pulse from the two-second timer
tick_en  out  1  enables the pacing timer
ram_addr  out  5  read address to RAM port B
ram_q  in  4  RAM port B data; valid one cycle after ram_addr
disp_digit  out  4  digit to random-number display decoder
disp_valid  out  1  disp_digit holds a sequence digit
busy  out  1  playback in progress
done  out  1  one-cycle pulse; playback complete

Function
REQ-002 The module SHALL have states IDLE, FETCH, WAIT, SHOW, GAP and DONE.
REQ-003 IDLE: start=1 latches the effective length L, clears index to 0, drives ram_addr=0 and moves to FETCH.
REQ-004 L SHALL be len clamped to 32; len=0 SHALL go from IDLE directly to DONE with no digit shown.
REQ-005 FETCH SHALL hold ram_addr=index for one cycle and then move to WAIT.
REQ-006 WAIT SHALL capture ram_q into disp_digit, set disp_valid=1 and move to SHOW.
REQ-007 The first digit SHALL therefore appear exactly 3 cycles after the start pulse.
REQ-008 SHOW SHALL hold the digit until tick=1, then blank the display and move to GAP.
REQ-009 Blanking SHALL drive disp_digit=4'hF and disp_valid=0.
REQ-010 GAP: on tick=1, if index==L-1 the module SHALL move to DONE; otherwise it SHALL increment index, set ram_addr=index+1 and move to FETCH.
REQ-011 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-012 tick_en SHALL be 1 only in SHOW and GAP; tick in any other state SHALL be ignored.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 abort SHALL return the module to IDLE on the next cycle from any state, with display blanked and no done pulse.
REQ-016 If abort and start arrive in the same cycle, abort SHALL win.
REQ-017 If tick and abort coincide, abort SHALL win.
REQ-018 The index SHALL be 5 bits; index 31 is the last legal address and the index SHALL never wrap.

Reset
REQ-019 While rst=1 the module SHALL be in IDLE with ram_addr=0, disp_digit=4'hF, disp_valid=0, busy=0, done=0, tick_en=0 and index=0.
REQ-020 rst asserted mid-playback SHALL take effect on the next edge and produce no done pulse.

Structure
REQ-021 The state encoding, the constant BLANK=4'hF and the constant MAX_LEN=32 SHALL live in the shared game package.
REQ-022 The module SHALL be a single FSM with an index counter and no sub-modules.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- RAM preloaded 3,7,1; len=3; start; tick every 20 cycles -> disp_digit 3,F,7,F,1,F in order; disp_digit=3 at start+3; done one cycle after the third GAP tick.
- len=0; start -> done pulse on the next cycle; disp_valid never 1; tick_en never 1.
- len=40 with all 32 RAM locations loaded -> exactly 32 digits shown; last ram_addr=31; done asserted.
- abort during the second SHOW of a 5-digit run -> IDLE next cycle, disp_digit=F, no done; a following start replays from address 0.
- start pulsed while busy, and tick pulsed during FETCH/WAIT -> no effect on sequence or timing.
- rst during GAP -> all outputs at reset values next cycle; done never asserted.
